// File: rtl/pmod_i2s_pkg.sv
// +--------------------------------------------------------------------------+
// | pmod_i2s_pkg : shared constants and types for the PmodI2S datapath       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package pmod_i2s_pkg;

  localparam int SAMPLE_W   = 16;
  // Shift window of the frame controller; must match SAMPLE_W.
  localparam int FRAME_BITS = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/pmod_i2s_serializer_if.sv
// +--------------------------------------------------------------------------+
// | pmod_i2s_serializer_if : controller strobes, sample stream and DAC pins  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pmod_i2s_serializer_if #(
  parameter int FIFO_DEPTH = 4
);
  import pmod_i2s_pkg::*;

  localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

  logic               cntr_load;
  logic               cntr_ncs;
  sample_t            s_data;
  logic               s_valid;
  logic               s_ready;
  logic               underrun_clr;
  logic               sdout;
  logic               lrck;
  logic               underrun;
  logic [LEVEL_W-1:0] fifo_level;

  modport master (
    output cntr_load, cntr_ncs, s_data, s_valid, underrun_clr,
    input  s_ready, sdout, lrck, underrun, fifo_level
  );

  modport slave (
    input  cntr_load, cntr_ncs, s_data, s_valid, underrun_clr,
    output s_ready, sdout, lrck, underrun, fifo_level
  );

endinterface

`default_nettype wire

// File: rtl/pmod_i2s_sample_fifo.sv
// +--------------------------------------------------------------------------+
// | pmod_i2s_sample_fifo : falling-edge synchronous sample FIFO              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pmod_i2s_sample_fifo
  import pmod_i2s_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEVEL_W    = $clog2(FIFO_DEPTH + 1)
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               push,
  input  wire sample_t            push_data,
  input  wire logic               pop,
  output      sample_t            head,
  output      logic               full,
  output      logic               empty,
  output      logic [LEVEL_W-1:0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  sample_t            r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [LEVEL_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == LEVEL_W'(FIFO_DEPTH));
  assign empty     = (r_count == '0);
  assign level     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + LEVEL_W'(1);
        2'b01:   r_count <= r_count - LEVEL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/pmod_i2s_serializer.sv
// +--------------------------------------------------------------------------+
// | pmod_i2s_serializer : buffers samples and shifts them MSB-first to DAC   |
// | Optional: PMODI2S_HOLD_LAST_EN repeats last sample on underrun. Rev 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pmod_i2s_serializer
  import pmod_i2s_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic           clk_sclk,
  input  wire logic           rst,
  pmod_i2s_serializer_if.slave bus
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

  sample_t            w_head;
  logic               w_full;
  logic               w_empty;
  logic [LEVEL_W-1:0] w_level;
  logic               w_frame_start;
  logic               w_frame_end;
  logic               w_pop;
  sample_t            w_fill;

  sample_t            r_shreg;
  logic               r_shreg_valid;
  logic               r_ncs_q;
  logic               r_lrck;
  logic               r_underrun;

  pmod_i2s_sample_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEVEL_W    (LEVEL_W)
  ) u_fifo (
    .clk       (clk_sclk),
    .rst       (rst),
    .push      (bus.s_valid),
    .push_data (bus.s_data),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (w_level)
  );

  assign w_frame_start = !bus.cntr_ncs && r_ncs_q;
  assign w_frame_end   = bus.cntr_ncs && !r_ncs_q;
  // The head is consumed only once its frame actually starts.
  assign w_pop         = w_frame_start && r_shreg_valid;

`ifdef PMODI2S_HOLD_LAST_EN
  sample_t r_last_sample;

  always_ff @(negedge clk_sclk or posedge rst) begin
    if (rst)        r_last_sample <= '0;
    else if (w_pop) r_last_sample <= r_shreg;
  end

  assign w_fill = r_last_sample;
`else
  assign w_fill = '0;
`endif

  always_ff @(negedge clk_sclk or posedge rst) begin
    if (rst) begin
      r_shreg       <= '0;
      r_shreg_valid <= 1'b0;
      r_ncs_q       <= 1'b1;
      r_lrck        <= LRCK_LEFT;
      r_underrun    <= 1'b0;
    end else begin
      r_ncs_q <= bus.cntr_ncs;

      if (bus.cntr_load) begin
        if (!w_empty) begin
          r_shreg       <= w_head;
          r_shreg_valid <= 1'b1;
        end else begin
          r_shreg       <= w_fill;
          r_shreg_valid <= 1'b0;
        end
      end else if (!bus.cntr_ncs) begin
        r_shreg <= {r_shreg[SAMPLE_W-2:0], 1'b0};
      end

      // A new underrun takes priority over a simultaneous clear.
      if (w_frame_start && !r_shreg_valid) r_underrun <= 1'b1;
      else if (bus.underrun_clr)           r_underrun <= 1'b0;

      if (w_frame_end) r_lrck <= !r_lrck;
    end
  end

  assign bus.sdout      = bus.cntr_ncs ? 1'b0 : r_shreg[SAMPLE_W-1];
  assign bus.s_ready    = !w_full;
  assign bus.fifo_level = w_level;
  assign bus.lrck       = r_lrck;
  assign bus.underrun   = r_underrun;

endmodule

`default_nettype wire

// File: doc/pmod_i2s_serializer.md
Name: pmod_i2s_serializer

Overview:
- Datapath stage directly downstream of the PmodI2S frame controller (PmodI2S_FSM).
- Consumes the controller's cntr_load/cntr_ncs strobes, buffers incoming audio samples in a small FIFO, and shifts each sample MSB-first onto the DAC serial data line.
- Generates LRCK and flags sample underruns to the alarm-tone source upstream.

Parameters:
- FIFO_DEPTH, 4, sample buffer entries; power of 2, >=2.
- SAMPLE_W, 16, bits per sample; must equal the controller's 16-cycle shift window.

Ports:
- clk_sclk  in  1  serial bit clock; all state updates on the falling edge.
- rst  in  1  asynchronous, active-high reset.
- cntr_load  in  1  controller in IDLE; load shift register.
- cntr_ncs  in  1  low during the 16 shift cycles.
- s_data  in  SAMPLE_W  sample from tone generator.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept; equals !full.
- underrun_clr  in  1  clears sticky underrun.
- sdout  out  1  serial data to DAC.
- lrck  out  1  channel select; 0 = left.
- underrun  out  1  sticky: a frame started with no sample.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied entries.

Behaviour:
- Reset values: shreg=0, shreg_valid=0, ncs_q=1, FIFO empty, fifo_level=0, s_ready=1, lrck=0, underrun=0. sdout=0 because cntr_ncs is high after reset.
- Reset mid-frame aborts the frame and discards all FIFO contents.
- Push: on an edge with s_valid && s_ready, s_data is written at the tail. When the FIFO is full, s_ready=0 and s_valid is ignored.
- Load: on every edge with cntr_load=1:
  - shreg <= FIFO head and shreg_valid <= 1 if the FIFO is non-empty;
  - otherwise shreg <= 0 and shreg_valid <= 0.
  - The head is not popped during load.
- Frame start is a cycle with cntr_ncs=0 && ncs_q=1. ncs_q is cntr_ncs registered on the falling edge.
- At the edge ending the frame-start cycle:
  - if shreg_valid, pop the head;
  - else set underrun.
- Shift: on each edge with cntr_ncs=0, shreg <= {shreg[SAMPLE_W-2:0],1'b0}.
- sdout = cntr_ncs ? 0 : shreg[SAMPLE_W-1], combinational.
- Output order: exactly 16 bits per frame, MSB first; no extra bit or gap.
- lrck toggles at the edge where ncs_q=0 && cntr_ncs=1 (frame end). It therefore holds the next frame's channel throughout IDLE/load.
- Simultaneous events:
  - Push and pop on the same edge: fifo_level unchanged, data ordering preserved.
  - Push into an empty FIFO during the last load cycle: the sample is not in that frame. That frame underruns and the new sample goes out in the next frame.
  - underrun_clr together with an underrun event: set wins.
- Pointers wrap modulo FIFO_DEPTH. fifo_level never exceeds FIFO_DEPTH and never goes negative.
- Latency: a sample pushed at edge N reaches sdout no earlier than the frame whose load phase includes the cycle after N.

Optional Feature:
- Macro: PMODI2S_HOLD_LAST_EN.
- Defined: an extra last_sample register captures shreg at every pop. On an underrun load, shreg <= last_sample instead of 0; underrun is still set and nothing is popped. last_sample resets to 0.
- Undefined: underrun frames transmit all zeros, and no last_sample register exists.

Decomposition:
- Shared package pmod_i2s_pkg:
  - SAMPLE_W=16 and FRAME_BITS=16 constants;
  - typedef sample_t (logic [SAMPLE_W-1:0]);
  - LRCK_LEFT/LRCK_RIGHT constants.
- The controller also uses FRAME_BITS.
- One sub-module: pmod_i2s_sample_fifo (synchronous FIFO, falling-edge, async reset; ports push/pop/head/full/empty/level).
- The serializer top holds the shift register, edge detection, lrck and underrun logic.

Test Plan:
- Reset: assert rst mid-frame with 3 samples queued -> fifo_level=0, s_ready=1, lrck=0, underrun=0, sdout=0 immediately. The next frame underruns.
- Single frame: push 16'hA5C3, drive controller idle->16 shift cycles -> sdout = 1010 0101 1100 0011 on consecutive cycles. fifo_level 1->0 after the first shift edge; lrck 0->1 at frame end.
- Backpressure: push 5 samples back-to-back with no frames -> first 4 accepted, s_ready=0 on the 5th, fifo_level=4. Then run one frame -> s_ready=1 and level=3.
- Ordering: push 16'h0001, 16'h8000, 16'hFFFF and run 3 frames -> bit streams match in order, and lrck alternates 1,0,1 after each frame.
- Underrun: empty FIFO, run a frame -> 16 zeros on sdout, underrun=1. Pulse underrun_clr on the same edge as a second underrun -> underrun stays 1. Clear alone -> 0.
- With PMODI2S_HOLD_LAST_EN: send 16'h1234, then an empty frame -> the second frame repeats 1234h bits, underrun=1.
